// File: rtl/sample_pkg.sv
// sample_pkg: Falcon RCDT constants and base-sampler FSM state encoding.
package sample_pkg;
  localparam int RCDT_LEN = 18;
  localparam logic [71:0] RCDT_TABLE [RCDT_LEN] = '{
    {24'd10745844, 24'd3068844,  24'd3741698},
    {24'd5559083,  24'd1580863,  24'd8248194},
    {24'd2260429,  24'd13669192, 24'd2736639},
    {24'd708981,   24'd4421575,  24'd10046180},
    {24'd169348,   24'd7122675,  24'd4136815},
    {24'd30538,    24'd13063405, 24'd7650655},
    {24'd4132,     24'd14505003, 24'd7826148},
    {24'd417,      24'd16768101, 24'd11363290},
    {24'd31,       24'd8444042,  24'd8086568},
    {24'd1,        24'd12844466, 24'd265321},
    {24'd0,        24'd1232676,  24'd13644283},
    {24'd0,        24'd38047,    24'd9111839},
    {24'd0,        24'd870,      24'd6138264},
    {24'd0,        24'd14,       24'd12545723},
    {24'd0,        24'd0,        24'd3104126},
    {24'd0,        24'd0,        24'd28824},
    {24'd0,        24'd0,        24'd198},
    {24'd0,        24'd0,        24'd1}
  };
  typedef enum logic [1:0] {IDLE, FETCH, CMP, DONE} sampler_state_t;
endpackage

// File: rtl/base_sampler.sv
// base_sampler: Falcon half-Gaussian base sampler, one RCDT compare per enabled cycle.
module base_sampler
  import sample_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       en,
  output logic       random_req,
  input  logic [7:0] random_bytes,
  output logic [4:0] z0,
  output logic       b,
  output logic       done
);
  sampler_state_t state;
  logic [71:0] v;
  logic [71:0] unused_diff;
  logic [3:0]  bidx;
  logic [4:0]  ci;
  logic [4:0]  acc;
  logic        b_int;
  logic        lt;
  assign random_req = en && state == FETCH;
  // v < table entry exactly when the 73-bit subtraction borrows
  assign {lt, unused_diff} = {1'b0, v} - {1'b0, RCDT_TABLE[ci]};
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      v     <= '0;
      bidx  <= '0;
      ci    <= '0;
      acc   <= '0;
      b_int <= 1'b0;
      z0    <= '0;
      b     <= 1'b0;
      done  <= 1'b0;
    end else if (en) begin
      case (state)
        IDLE: if (start) begin
          state <= FETCH;
          acc   <= '0;
          bidx  <= '0;
        end
        FETCH: begin
          bidx <= bidx + 4'd1;
          if (bidx == 4'd9) begin
            b_int <= random_bytes[0];
            ci    <= '0;
            state <= CMP;
          end else
            v <= {random_bytes, v[71:8]};
        end
        CMP: begin
          acc <= acc + {4'd0, lt};
          ci  <= (ci == 5'(RCDT_LEN - 1)) ? 5'd0 : ci + 5'd1;
          if (ci == 5'(RCDT_LEN - 1)) begin
            z0    <= acc + {4'd0, lt};
            b     <= b_int;
            done  <= 1'b1;
            state <= DONE;
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_base_sampler.sv
// tb_base_sampler: directed scoreboard bench for the RCDT base sampler.
module tb_base_sampler;
  import sample_pkg::*;
  typedef struct {
    int z;
    int b;
    int c;
  } exp_t;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       en = 1'b0;
  logic       random_req;
  logic [7:0] random_bytes;
  logic [4:0] z0;
  logic       b;
  logic       done;
  logic [7:0] feed [10];
  int cyc = 0;
  int cons_cnt = 0;
  int base = 0;
  int t0 = 0;
  int checks = 0;
  int passes = 0;
  int fails = 0;
  int rd = 0;
  int obs_n = 0;
  int obs_z [64];
  int obs_b [64];
  int obs_c [64];
  logic done_q = 1'b0;
  exp_t sb [$];

  base_sampler dut (
    .clk(clk), .rst_n(rst_n), .start(start), .en(en),
    .random_req(random_req), .random_bytes(random_bytes),
    .z0(z0), .b(b), .done(done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) if (random_req && en) cons_cnt <= cons_cnt + 1;
  assign random_bytes = (cons_cnt - base >= 0 && cons_cnt - base < 10) ? feed[cons_cnt - base] : 8'h00;

  always @(negedge clk) begin
    done_q <= done;
    if (done && !done_q && obs_n < 64) begin
      obs_z[obs_n] <= int'(z0);
      obs_b[obs_n] <= int'(b);
      obs_c[obs_n] <= cyc;
      obs_n <= obs_n + 1;
    end
  end

  function automatic int exp_z0(input logic [71:0] v);
    int n = 0;
    for (int i = 0; i < RCDT_LEN; i++) if (v < RCDT_TABLE[i]) n++;
    return n;
  endfunction

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic goto(input int c);
    while (cyc < c) tick();
  endtask

  task automatic draw_start(input logic [71:0] v, input logic [7:0] byte9, input bit push, input int delay);
    exp_t e;
    base = cons_cnt;
    for (int k = 0; k < 9; k++) feed[k] = v[8*k +: 8];
    feed[9] = byte9;
    start = 1'b1;
    t0 = cyc;
    e.z = exp_z0(v);
    e.b = int'(byte9[0]);
    e.c = t0 + 29 + delay;
    if (push) sb.push_back(e);
    tick();
    start = 1'b0;
  endtask

  task automatic finish_draw(input string tag);
    exp_t e;
    int k = 0;
    while (obs_n == rd && k < 200) begin
      tick();
      k++;
    end
    e = sb.pop_front();
    if (obs_n == rd) chk({tag, "_timeout"}, obs_n, rd + 1);
    else begin
      chk({tag, "_z0"}, obs_z[rd], e.z);
      chk({tag, "_b"}, obs_b[rd], e.b);
      chk({tag, "_done_cycle"}, obs_c[rd], e.c);
      rd++;
    end
  endtask

  initial begin
    tick();
    tick();
    chk("reset_z0", int'(z0), 0);
    chk("reset_b", int'(b), 0);
    chk("reset_done", int'(done), 0);
    chk("reset_req", int'(random_req), 0);
    rst_n = 1'b1;
    en = 1'b1;
    tick();
    draw_start(72'd0, 8'h01, 1, 0);
    chk("zeros_expected_z0", sb[0].z, 18);
    finish_draw("zeros");
    draw_start({72{1'b1}}, 8'hFE, 1, 0);
    finish_draw("ones");
    draw_start(RCDT_TABLE[17], 8'h03, 1, 0);
    finish_draw("tab17");
    draw_start(RCDT_TABLE[17] - 72'd1, 8'h00, 1, 0);
    finish_draw("tab17_m1");
    draw_start(RCDT_TABLE[0], 8'h81, 1, 0);
    finish_draw("tab0");
    for (int r = 0; r < 3; r++) begin
      draw_start(RCDT_TABLE[$urandom_range(17, 0)] - 72'($urandom_range(1, 0)), 8'($urandom), 1, 0);
      finish_draw("rand_edge");
    end
    draw_start(72'd0, 8'h01, 1, 3);
    goto(t0 + 5);
    en = 1'b0;
    for (int s = 0; s < 3; s++) begin
      @(negedge clk);
      chk("stall_req_low", int'(random_req), 0);
      tick();
    end
    en = 1'b1;
    finish_draw("stall");
    draw_start(RCDT_TABLE[5], 8'h01, 0, 0);
    goto(t0 + 15);
    rst_n = 1'b0;
    #1;
    chk("midrst_z0", int'(z0), 0);
    chk("midrst_b", int'(b), 0);
    chk("midrst_done", int'(done), 0);
    chk("midrst_req", int'(random_req), 0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("midrst_no_done", obs_n, rd);
    draw_start(RCDT_TABLE[5], 8'h01, 1, 0);
    finish_draw("after_rst");
    draw_start(RCDT_TABLE[3] - 72'd1, 8'h00, 1, 0);
    goto(t0 + 4);
    start = 1'b1;
    tick();
    start = 1'b0;
    goto(t0 + 29);
    start = 1'b1;
    tick();
    start = 1'b0;
    finish_draw("ignored_start");
    repeat (40) tick();
    chk("no_extra_done", obs_n, rd);
    chk("scoreboard_empty", sb.size(), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule

// File: doc/base_sampler.md
BASE_SAMPLER -- requirements
Module: base_sampler

Interface
REQ-001 SHALL have port clk, input, 1, clock; all registers rising-edge.
REQ-002 SHALL have port rst_n, input, 1, reset, asynchronous, active-low.
REQ-003 SHALL have port start, input, 1, requests one half-Gaussian draw; sampled only in IDLE with en=1.
REQ-004 SHALL have port en, input, 1, global advance enable; en=0 freezes all state.
REQ-005 SHALL have port random_req, output, 1, requests one random byte in the current cycle.
REQ-006 SHALL have port random_bytes, input, 8, byte consumed in the same cycle that random_req=1 and en=1.
REQ-007 SHALL have port z0, output, 5, base-sampler result, range 0..18.
REQ-008 SHALL have port b, output, 1, sign-selection bit for the downstream z = b + (2b-1)*z0 stage.
REQ-009 SHALL have port done, output, 1, one-cycle pulse; z0 and b are valid from this cycle.

Function
REQ-010 SHALL implement FSM states IDLE, FETCH, CMP, DONE.
REQ-011 SHALL move IDLE->FETCH on a clock edge where start=1 and en=1.
REQ-012 SHALL ignore start in every state except IDLE.
REQ-013 SHALL drive random_req = en AND (state==FETCH); random_req is combinational from registered state.
REQ-014 SHALL consume exactly 10 bytes in FETCH, one per cycle where random_req=1.
REQ-015 Bytes 0..8 SHALL form the 72-bit value v, little-endian: byte 0 -> v[7:0], byte 8 -> v[71:64].
REQ-016 Byte 9 SHALL set the internal b register to byte9[0].
REQ-017 SHALL move FETCH->CMP after byte 9 is consumed.
REQ-018 In CMP, SHALL evaluate one entry per en cycle for index i=0..17: acc += (v < RCDT_TABLE[i]).
REQ-019 Each comparison SHALL be an unsigned 72-bit compare using the borrow of v - RCDT_TABLE[i].
REQ-020 SHALL move CMP->DONE after i=17.
REQ-021 In DONE, SHALL load z0 from acc and the output b from the internal b register, assert done for one en cycle, then return to IDLE.
REQ-022 With en held high and start at cycle 0: random_req=1 in cycles 1..10, CMP in cycles 11..28, done=1 in cycle 29.
REQ-023 Each en=0 cycle SHALL delay all later events by exactly one cycle.
REQ-024 If en=0 while in DONE, done SHALL stay high until the next en=1 cycle, then clear.
REQ-025 z0 and b SHALL hold their values from DONE until the next DONE.
REQ-026 acc and the byte index SHALL clear on the IDLE->FETCH transition.
REQ-027 start=1 in the same cycle as done: start SHALL be ignored, because state is DONE, not IDLE.

Reset
REQ-028 rst_n=0 SHALL force state=IDLE, z0=0, b=0, done=0, random_req=0, acc=0, byte index=0, compare index=0.
REQ-029 Reset asserted mid-FETCH or mid-CMP SHALL abandon the draw with no done pulse; the next start begins a fresh 10-byte fetch.

Structure
REQ-030 RCDT_TABLE (18 x 72-bit, strictly decreasing Falcon RCDT constants) and RCDT_LEN=18 SHALL live in sample_pkg.
REQ-031 The FSM state enum for this block SHALL live in sample_pkg.
REQ-032 No sub-module SHALL be used; the 72-bit compare and the byte shift-in SHALL be inline.
REQ-033 Output z0 and b SHALL feed the downstream x computation ahead of berexp without re-registering.

Verification
REQ-034 Nine bytes 0x00, then byte 0x01 -> z0=18, b=1, done at cycle 29.
REQ-035 Nine bytes 0xFF, then byte 0xFE -> z0=0, b=0.
REQ-036 v = RCDT_TABLE[17] -> z0=17; v = RCDT_TABLE[17]-1 -> z0=18; v = RCDT_TABLE[0] -> z0=0.
REQ-037 Drop en for 3 cycles at cycle 5 -> random_req low while en=0, done at cycle 32, z0 identical to the unstalled run.
REQ-038 Assert rst_n=0 at cycle 15 (CMP), then restart -> no done from the first draw, all outputs 0, second draw correct with done 29 cycles after its start.
REQ-039 start pulsed during FETCH and again coincident with done -> both ignored, exactly one done pulse per accepted start.
